touch_key_ctrl: RTL

TOUCH_KEY_CTRL -- requirements
Module: touch_key_ctrl

---
 rtl/touch_key_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/touch_key_ctrl.sv
// Multi-channel capacitive touch key controller: per-channel synchroniser,
// debounce/long-press FSM, and a shared toggle/momentary/radio switch state.

module touch_key_ch #(
  parameter int DEB_CYC  = 20,
  parameter int LONG_CYC = 50_000_000,
  parameter int CW       = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o,
  output logic long_o,
  output logic active_o
);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG, DEB_REL} state_e;

  localparam logic [CW-1:0] DEB_M1  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    sync_q;
  logic          press_q, press_d, long_q, long_d;
  logic          from_long_q, from_long_d;
  logic          lvl;

  assign lvl      = sync_q[1];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign press_o  = press_q;
  assign long_o   = long_q;
  assign active_o = (state_q == HELD) || (state_q == LONG) || (state_q == DEB_REL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
      from_long_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      long_q      <= long_d;
      from_long_q <= from_long_d;
    end
  end

  // Debounce counts start at 0 on entry, so the entry cycle is not part of the DEB_CYC run.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    long_d      = 1'b0;
    from_long_d = from_long_q;
    case (state_q)
      IDLE: if (lvl) begin
        state_d = DEB_PRESS;
        cnt_d   = '0;
      end
      DEB_PRESS: begin
        if (!lvl) state_d = IDLE;
        else if (cnt_q >= DEB_M1) begin
          state_d     = HELD;
          cnt_d       = '0;
          press_d     = 1'b1;
          from_long_d = 1'b0;
        end else cnt_d = cnt_inc;
      end
      HELD: begin
        if (!lvl) begin
          state_d     = DEB_REL;
          cnt_d       = '0;
          from_long_d = 1'b0;
        end else if (cnt_q >= LONG_M1) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_d   = cnt_inc;
        end else cnt_d = cnt_inc;
      end
      LONG: if (!lvl) begin
        state_d     = DEB_REL;
        cnt_d       = '0;
        from_long_d = 1'b1;
      end
      DEB_REL: begin
        if (lvl) begin
          state_d = from_long_q ? LONG : HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

module touch_key_ctrl #(
  parameter int CH          = 4,
  parameter int DEB_CYC     = 20,
  parameter int LONG_CYC    = 50_000_000,
  parameter bit LED_ACT_LOW = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] touch_key,
  input  logic [1:0]    mode,
  output logic [CH-1:0] led,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] long_pulse,
  output logic [CH-1:0] sw_state
);
  localparam int CW = $clog2(LONG_CYC + 1);

  logic [CH-1:0] press_w, long_w, active_w;
  logic [CH-1:0] sw_q, sw_d, led_q;
  logic          found;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    touch_key_ch #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .CW(CW)) u_ch (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .key_i   (touch_key[g]),
      .press_o (press_w[g]),
      .long_o  (long_w[g]),
      .active_o(active_w[g])
    );
  end

  assign press_pulse = press_w;
  assign long_pulse  = long_w;
  assign sw_state    = sw_q;
  assign led         = led_q;

  always_comb begin
    sw_d  = sw_q;
    found = 1'b0;
    case (mode)
      2'b01: sw_d = active_w;
      2'b10: begin
        // Radio mode: only the lowest-index press in a cycle wins.
        for (int i = 0; i < CH; i++) begin
          if (!found && press_w[i]) begin
            found = 1'b1;
            sw_d  = '0;
            if (!sw_q[i]) sw_d[i] = 1'b1;
          end
        end
      end
      default: sw_d = (|long_w) ? '0 : (sw_q ^ press_w);
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sw_q  <= '0;
      led_q <= {CH{LED_ACT_LOW}};
    end else begin
      sw_q  <= sw_d;
      led_q <= sw_d ^ {CH{LED_ACT_LOW}};
    end
  end
endmodule
